// File: rtl/depacketizer_rr_arbiter.sv
// Round-robin flit arbiter in front of a single depacketizer. Arbitration
// happens only on head flits; the winner owns the output until its tail leaves.
module depacketizer_rr_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int WIDTH_PKT     = 36,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*WIDTH_PKT-1:0] data_in,
  input  logic [NUM_PORTS-1:0]           valid_in,
  output logic [NUM_PORTS-1:0]           ready_out,
  output logic [WIDTH_PKT-1:0]           data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [PORT_ID_WIDTH-1:0]       grant_id,
  output logic                           locked
);

  localparam int HEAD_BIT = WIDTH_PKT - 2;
  localparam int TAIL_BIT = WIDTH_PKT - 3;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                      state_q;
  logic [PORT_ID_WIDTH-1:0]    ptr_q, owner_q, grant_q;
  logic [WIDTH_PKT-1:0]        data_q;
  logic                        valid_q;

  logic [NUM_PORTS-1:0][WIDTH_PKT-1:0] flits;
  logic [NUM_PORTS-1:0]        cand;
  logic [PORT_ID_WIDTH-1:0]    sel, idx;
  logic                        found, can_load, xfer, sel_tail;
  logic [WIDTH_PKT-1:0]        sel_flit;

  assign flits = data_in;

  function automatic logic [PORT_ID_WIDTH-1:0] wrap_inc(input logic [PORT_ID_WIDTH-1:0] p);
    if (p == PORT_ID_WIDTH'(NUM_PORTS - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Locked: owner is the only grantee. Idle: first head request at/after ptr_q.
  always_comb begin
    cand  = '0;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) cand[i] = valid_in[i] & flits[i][HEAD_BIT];
    if (state_q == LOCKED) begin
      sel   = owner_q;
      found = 1'b1;
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = PORT_ID_WIDTH'((int'(ptr_q) + k) % NUM_PORTS);
        if (cand[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign can_load = ~valid_q | ready_in;

  always_comb begin
    ready_out = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      ready_out[i] = can_load & found & (sel == PORT_ID_WIDTH'(i));
  end

  assign xfer     = |(ready_out & valid_in);
  assign sel_flit = flits[sel];
  assign sel_tail = sel_flit[TAIL_BIT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        data_q  <= sel_flit;
        valid_q <= 1'b1;
        grant_q <= sel;
        case (state_q)
          IDLE: begin
            if (sel_tail) ptr_q <= wrap_inc(sel);
            else begin
              state_q <= LOCKED;
              owner_q <= sel;
            end
          end
          LOCKED: begin
            if (sel_tail) begin
              state_q <= IDLE;
              ptr_q   <= wrap_inc(owner_q);
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (ready_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_id  = grant_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_depacketizer_rr_arbiter.sv
// Directed bench for depacketizer_rr_arbiter: packet locking, round-robin
// order, wrap-around, backpressure hold and mid-packet reset.
module tb_depacketizer_rr_arbiter;
  localparam int NP = 4;
  localparam int W  = 36;
  localparam int PW = 2;

  logic             clk;
  logic             rst;
  logic [NP*W-1:0]  data_in;
  logic [NP-1:0]    valid_in;
  logic [NP-1:0]    ready_out;
  logic [W-1:0]     data_out;
  logic             valid_out;
  logic             ready_in;
  logic [PW-1:0]    grant_id;
  logic             locked;

  int total = 0;
  int bad   = 0;

  depacketizer_rr_arbiter #(.NUM_PORTS(NP), .WIDTH_PKT(W), .PORT_ID_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .grant_id(grant_id), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic h, input logic t, input logic [7:0] tag);
    return {1'b1, h, t, 25'd0, tag};
  endfunction

  task automatic set_flit(input int p, input logic [W-1:0] f);
    data_in[p*W +: W] = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = '0;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_data",  64'(data_out),  64'd0);
    chk("rst_gid",   64'(grant_id),  64'd0);
    chk("rst_lock",  64'(locked),    64'd0);
  endtask

  initial begin
    data_in  = '0;
    valid_in = '0;
    ready_in = 1'b1;
    rst      = 1'b0;
    do_reset();

    // 3-flit packet from port 2
    set_flit(2, mk(1, 0, 8'h21)); valid_in = 4'b0100; #1;
    chk("t1_rdy_h", 64'(ready_out), 64'b0100);
    tick();
    chk("t1_v_h", 64'(valid_out), 64'd1);
    chk("t1_d_h", 64'(data_out), 64'(mk(1, 0, 8'h21)));
    chk("t1_g_h", 64'(grant_id), 64'd2);
    chk("t1_l_h", 64'(locked), 64'd1);
    set_flit(2, mk(0, 0, 8'h22)); #1;
    chk("t1_rdy_b", 64'(ready_out), 64'b0100);
    tick();
    chk("t1_d_b", 64'(data_out), 64'(mk(0, 0, 8'h22)));
    chk("t1_l_b", 64'(locked), 64'd1);
    set_flit(2, mk(0, 1, 8'h23)); #1;
    tick();
    chk("t1_d_t", 64'(data_out), 64'(mk(0, 1, 8'h23)));
    chk("t1_v_t", 64'(valid_out), 64'd1);
    chk("t1_g_t", 64'(grant_id), 64'd2);
    chk("t1_l_t", 64'(locked), 64'd0);
    valid_in = '0;
    tick();
    chk("t1_v_end", 64'(valid_out), 64'd0);

    // pointer now 3: ports 3 and 0 request, 3 first then wrap to 0
    set_flit(3, mk(1, 1, 8'h30)); set_flit(0, mk(1, 1, 8'h01)); valid_in = 4'b1001; #1;
    chk("t5_rdy3", 64'(ready_out), 64'b1000);
    tick();
    chk("t5_g3", 64'(grant_id), 64'd3);
    chk("t5_d3", 64'(data_out), 64'(mk(1, 1, 8'h30)));
    set_flit(3, mk(1, 1, 8'h31)); set_flit(0, mk(1, 1, 8'h02)); #1;
    chk("t5_rdy0", 64'(ready_out), 64'b0001);
    tick();
    chk("t5_g0", 64'(grant_id), 64'd0);
    chk("t5_d0", 64'(data_out), 64'(mk(1, 1, 8'h02)));
    valid_in = '0;
    tick();

    do_reset();

    // all ports with single-flit packets: rotation 0,1,2,3,0,1
    valid_in = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) set_flit(p, mk(1, 1, 8'(16 * p + k)));
      #1;
      chk("t2_rdy", 64'(ready_out), 64'(4'b0001 << (k % 4)));
      tick();
      chk("t2_gid", 64'(grant_id), 64'(k % 4));
      chk("t2_data", 64'(data_out), 64'(mk(1, 1, 8'(16 * (k % 4) + k))));
      chk("t2_valid", 64'(valid_out), 64'd1);
    end

    // backpressure hold with port 1's flit in the output register
    for (int p = 0; p < NP; p++) set_flit(p, mk(1, 1, 8'(16 * p + 6)));
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_rdy0", 64'(ready_out), 64'd0);
      tick();
      chk("t4_hold_d", 64'(data_out), 64'(mk(1, 1, 8'h15)));
      chk("t4_hold_g", 64'(grant_id), 64'd1);
      chk("t4_hold_v", 64'(valid_out), 64'd1);
    end
    ready_in = 1'b1; #1;
    chk("t4_rel_rdy", 64'(ready_out), 64'b0100);
    tick();
    chk("t4_rel_g", 64'(grant_id), 64'd2);
    chk("t4_rel_d", 64'(data_out), 64'(mk(1, 1, 8'h26)));
    for (int p = 0; p < NP; p++) set_flit(p, mk(1, 1, 8'(16 * p + 7)));
    tick();
    chk("t4_next_g", 64'(grant_id), 64'd3);
    chk("t4_next_d", 64'(data_out), 64'(mk(1, 1, 8'h37)));
    valid_in = '0;
    tick();
    chk("t4_idle_v", 64'(valid_out), 64'd0);

    // port 0 locked, port 1 head waits until after the tail
    set_flit(0, mk(1, 0, 8'h0A)); valid_in = 4'b0001; #1;
    tick();
    chk("t3_lock", 64'(locked), 64'd1);
    set_flit(0, mk(0, 0, 8'h0B)); set_flit(1, mk(1, 1, 8'h1A)); valid_in = 4'b0011; #1;
    chk("t3_rdy_b", 64'(ready_out), 64'b0001);
    tick();
    chk("t3_d_b", 64'(data_out), 64'(mk(0, 0, 8'h0B)));
    valid_in = 4'b0010; #1;
    chk("t3_rdy1_bub", 64'(ready_out[1]), 64'd0);
    tick();
    chk("t3_bub_v", 64'(valid_out), 64'd0);
    chk("t3_bub_l", 64'(locked), 64'd1);
    set_flit(0, mk(0, 1, 8'h0C)); valid_in = 4'b0011; #1;
    chk("t3_rdy_t", 64'(ready_out), 64'b0001);
    tick();
    chk("t3_d_t", 64'(data_out), 64'(mk(0, 1, 8'h0C)));
    chk("t3_g_t", 64'(grant_id), 64'd0);
    chk("t3_l_t", 64'(locked), 64'd0);
    valid_in = 4'b0010; #1;
    chk("t3_rdy1", 64'(ready_out), 64'b0010);
    tick();
    chk("t3_g1", 64'(grant_id), 64'd1);
    chk("t3_d1", 64'(data_out), 64'(mk(1, 1, 8'h1A)));

    // reset during a locked packet from port 1
    set_flit(1, mk(1, 0, 8'h1B)); valid_in = 4'b0010; #1;
    tick();
    chk("t6_lock", 64'(locked), 64'd1);
    chk("t6_gid1", 64'(grant_id), 64'd1);
    rst = 1'b0;
    set_flit(1, mk(0, 0, 8'h1C));
    tick();
    rst = 1'b1;
    chk("t6_v", 64'(valid_out), 64'd0);
    chk("t6_l", 64'(locked), 64'd0);
    chk("t6_g", 64'(grant_id), 64'd0);
    #1;
    chk("t6_nohead_rdy", 64'(ready_out), 64'd0);
    set_flit(0, mk(1, 1, 8'h0D)); valid_in = 4'b0011; #1;
    chk("t6_rdy0", 64'(ready_out), 64'b0001);
    tick();
    chk("t6_g0", 64'(grant_id), 64'd0);
    chk("t6_d0", 64'(data_out), 64'(mk(1, 1, 8'h0D)));
    chk("t6_v0", 64'(valid_out), 64'd1);
    valid_in = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
